// File: rtl/dice_roller.sv
// Push-button dice roller: synchronises and debounces a raw button, spins a 1..6 face while
// held, slows down geometrically after release, then holds the result until the next press.
module dice_roller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ROLL_DIV        = 1000,
  parameter int unsigned SLOW_STEPS      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       button_i,
  input  logic       lamp_test_i,
  output logic [2:0] dice_value_o,
  output logic       rolling_o
);

  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW  = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
  localparam int unsigned IntW  = $clog2(ROLL_DIV << (SLOW_STEPS + 1)) + 1;
  localparam int unsigned StepW = (SLOW_STEPS > 0) ? $clog2(SLOW_STEPS + 1) : 1;

  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0]  DivLast   = DivW'(ROLL_DIV - 1);
  localparam logic [IntW-1:0]  SlowStart = IntW'(2 * ROLL_DIV);
  localparam logic [StepW-1:0] StepLast  = StepW'(SLOW_STEPS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRoll = 2'd1;
  localparam logic [1:0] StSlow = 2'd2;
  localparam logic [1:0] StShow = 2'd3;

  function automatic logic [2:0] next_face(input logic [2:0] v);
    return (v == 3'd6) ? 3'd1 : v + 3'd1;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Input synchroniser and debounce
  // ---------------------------------------------------------------------------------------------
  logic           sync1_q, sync2_q;
  logic           db_q, db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           differ;
  logic           db_toggle;
  logic           press_pulse;
  logic           release_pulse;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= button_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Pulses fire on the cycle the debounced level is about to flip, so the FSM moves on the
  // same edge as the debounced register.
  always_comb begin
    differ        = sync2_q ^ db_q;
    db_toggle     = differ && (db_cnt_q == DbLast);
    db_d          = db_toggle ? ~db_q : db_q;
    db_cnt_d      = (!differ || db_toggle) ? '0 : db_cnt_q + DbW'(1);
    press_pulse   = db_toggle & ~db_q;
    release_pulse = db_toggle & db_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Roll / slow-down FSM
  // ---------------------------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [2:0]       value_q, value_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [IntW-1:0]  slow_cnt_q, slow_cnt_d;
  logic [IntW-1:0]  interval_q, interval_d;
  logic [StepW-1:0] steps_q, steps_d;
  logic             rolling_q, rolling_d;
  logic             slow_step;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      value_q    <= 3'd0;
      div_q      <= '0;
      slow_cnt_q <= '0;
      interval_q <= '0;
      steps_q    <= '0;
      rolling_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      div_q      <= div_d;
      slow_cnt_q <= slow_cnt_d;
      interval_q <= interval_d;
      steps_q    <= steps_d;
      rolling_q  <= rolling_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    div_d      = div_q;
    slow_cnt_d = slow_cnt_q;
    interval_d = interval_q;
    steps_d    = steps_q;
    slow_step  = (slow_cnt_q == (interval_q - IntW'(1)));

    unique case (state_q)
      StIdle: begin
        value_d = 3'd0;
        if (press_pulse) begin
          state_d = StRoll;
          value_d = 3'd1;
          div_d   = '0;
        end
      end

      StRoll: begin
        // A release suppresses the advance that would otherwise land on the same edge.
        if (release_pulse) begin
          state_d    = StSlow;
          interval_d = SlowStart;
          slow_cnt_d = '0;
          steps_d    = '0;
        end else if (div_q == DivLast) begin
          div_d   = '0;
          value_d = next_face(value_q);
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StSlow: begin
        if (slow_step) begin
          value_d    = next_face(value_q);
          slow_cnt_d = '0;
          steps_d    = steps_q + StepW'(1);
          interval_d = {interval_q[IntW-2:0], 1'b0};
          if (steps_q == StepLast) begin
            state_d = StShow;
          end
        end else begin
          slow_cnt_d = slow_cnt_q + IntW'(1);
        end
        // A press wins over a coincident final step: the value still advances.
        if (press_pulse) begin
          state_d = StRoll;
          div_d   = '0;
        end
      end

      StShow: begin
        if (press_pulse) begin
          state_d = StRoll;
          div_d   = '0;
        end
      end

      default: begin
        state_d = StIdle;
        value_d = 3'd0;
      end
    endcase

    rolling_d = (state_d == StRoll) || (state_d == StSlow);
  end

  assign rolling_o    = rolling_q;
  assign dice_value_o = lamp_test_i ? 3'd7 : value_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed-plus-random bench for dice_roller, checked every cycle against a cycle-count model.
module tb_dice_roller;

  localparam int DB = 4;
  localparam int RD = 2;
  localparam int SS = 3;

  localparam int MIdle = 0;
  localparam int MRoll = 1;
  localparam int MSlow = 2;
  localparam int MShow = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       button_i;
  logic       lamp_test_i;
  logic [2:0] dice_value_o;
  logic       rolling_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: button pipeline, run length of disagreement, face and countdown to next step.
  int m_s1, m_s2, m_db, m_run;
  int m_mode, m_face, m_left, m_steps, m_interval;

  always #5 clk_i = ~clk_i;

  dice_roller #(
    .DEBOUNCE_CYCLES(DB),
    .ROLL_DIV       (RD),
    .SLOW_STEPS     (SS)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .button_i    (button_i),
    .lamp_test_i (lamp_test_i),
    .dice_value_o(dice_value_o),
    .rolling_o   (rolling_o)
  );

  function automatic int next_face(input int f);
    return (f % 6) + 1;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
    m_mode = MIdle; m_face = 0; m_left = 0; m_steps = 0; m_interval = 0;
  endtask

  task automatic model_edge();
    int press_ev;
    int rel_ev;
    press_ev = 0;
    rel_ev   = 0;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db     = m_s2;
        m_run    = 0;
        press_ev = m_db;
        rel_ev   = 1 - m_db;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(button_i);
    case (m_mode)
      MIdle: if (press_ev != 0) begin
        m_mode = MRoll; m_face = 1; m_left = RD;
      end
      MRoll: begin
        if (rel_ev != 0) begin
          m_mode = MSlow; m_interval = 2 * RD; m_left = m_interval; m_steps = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_face = next_face(m_face); m_left = RD;
          end
        end
      end
      MSlow: begin
        m_left--;
        if (m_left == 0) begin
          m_face = next_face(m_face);
          m_steps++;
          m_interval = m_interval * 2;
          m_left = m_interval;
          if (m_steps == SS) m_mode = MShow;
        end
        if (press_ev != 0) begin
          m_mode = MRoll; m_left = RD;
        end
      end
      default: if (press_ev != 0) begin
        m_mode = MRoll; m_left = RD;
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic [2:0] exp_dv;
    logic       exp_roll;
    exp_dv   = lamp_test_i ? 3'd7 : 3'(m_face);
    exp_roll = (m_mode == MRoll) || (m_mode == MSlow);
    n_checks++;
    assert (dice_value_o === exp_dv) else begin
      n_fail++;
      $error("FAIL %s: dice_value observed %0d expected %0d", tag, dice_value_o, exp_dv);
    end
    n_checks++;
    assert (rolling_o === exp_roll) else begin
      n_fail++;
      $error("FAIL %s: rolling observed %0b expected %0b", tag, rolling_o, exp_roll);
    end
  endtask

  task automatic step(input string tag);
    if (rst_ni) model_edge();
    else model_reset();
    @(posedge clk_i);
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic directed(input string tag, input logic [2:0] dv, input logic roll);
    n_checks++;
    assert (dice_value_o === dv && rolling_o === roll) else begin
      n_fail++;
      $error("FAIL %s: observed value %0d rolling %0b, expected value %0d rolling %0b",
             tag, dice_value_o, rolling_o, dv, roll);
    end
  endtask

  task automatic wait_mode(input int mode, input int limit, input string tag);
    int i;
    i = 0;
    while (m_mode != mode && i < limit) begin
      step(tag);
      i++;
    end
    n_checks++;
    assert (m_mode == mode) else begin
      n_fail++;
      $error("FAIL %s: timeout, model mode %0d expected %0d", tag, m_mode, mode);
    end
  endtask

  initial begin
    int i;
    rst_ni      = 1'b0;
    button_i    = 1'b0;
    lamp_test_i = 1'b0;
    model_reset();
    run(3, "reset");
    rst_ni = 1'b1;
    run(20, "idle");

    lamp_test_i = 1'b1;
    run(4, "lamp_idle");
    lamp_test_i = 1'b0;
    run(2, "lamp_idle_off");

    // Short pulses must not survive the debounce.
    button_i = 1'b1;
    step("glitch1");
    button_i = 1'b0;
    run(8, "glitch1_after");
    button_i = 1'b1;
    run(3, "glitch3");
    button_i = 1'b0;
    run(10, "glitch3_after");

    button_i = 1'b1;
    run(5, "press_wait");
    directed("press_not_yet", 3'd0, 1'b0);
    step("press_edge");
    directed("press_latency", 3'd1, 1'b1);
    run(30, "roll_wrap");

    lamp_test_i = 1'b1;
    run(4, "lamp_roll");
    lamp_test_i = 1'b0;

    // Release so that the release lands with face 3 showing.
    i = 0;
    while (!(m_face == 1 && m_left == RD) && i < 20) begin
      step("align_release");
      i++;
    end
    n_checks++;
    assert (m_face == 1 && m_left == RD) else begin
      n_fail++;
      $error("FAIL align_release: timeout, model face %0d expected 1", m_face);
    end
    button_i = 1'b0;
    run(6, "release");
    directed("release_value", 3'd3, 1'b1);
    run(27, "slow");
    directed("slow_last", 3'd5, 1'b1);
    step("slow_done");
    directed("show_entry", 3'd6, 1'b0);
    run(100, "show_hold");

    lamp_test_i = 1'b1;
    run(5, "lamp_show");
    lamp_test_i = 1'b0;
    run(3, "lamp_show_off");

    button_i = 1'b1;
    run(10, "reroll");
    button_i = 1'b0;
    wait_mode(MSlow, 20, "to_slow");
    i = 0;
    while (m_steps < 1 && i < 20) begin
      step("slow_first_step");
      i++;
    end
    button_i = 1'b1;
    run(20, "slow_press");
    button_i = 1'b0;
    run(60, "slow_press_release");

    for (int seg = 0; seg < 40; seg++) begin
      button_i    = 1'($urandom_range(0, 1));
      lamp_test_i = ($urandom_range(0, 7) == 0);
      run(int'($urandom_range(1, 30)), "random");
    end
    lamp_test_i = 1'b0;

    // Asynchronous reset in the middle of SLOW.
    button_i = 1'b0;
    run(12, "settle");
    button_i = 1'b1;
    wait_mode(MRoll, 40, "to_roll");
    run(3, "roll_again");
    button_i = 1'b0;
    wait_mode(MSlow, 20, "to_slow2");
    run(2, "slow2");
    rst_ni = 1'b0;
    #1;
    directed("async_reset", 3'd0, 1'b0);
    model_reset();
    run(2, "in_reset");
    rst_ni = 1'b1;
    run(10, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
